// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the multicycle control unit and the HI/LO multiply-divide unit.
interface hilo_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI_Q;
  logic [31:0] LO_Q;

  modport master (output start, op, A, B, input busy, done, HI_Q, LO_Q);
  modport slave  (input start, op, A, B, output busy, done, HI_Q, LO_Q);
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative shift-add multiplier / restoring divider writing HI and LO; MTHI/MTLO write in one edge.
// Mul/div holds busy for 32 cycles then pulses done; any start while busy is dropped (no queueing).
module hilo_muldiv (
  input  logic               clk,
  input  logic               rst,
  hilo_muldiv_if.slave       bus
);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam int         ITERS    = 32;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] mag_a, mag_b;
  logic        is_div, neg_q, neg_r;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        issue_md, last;
  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag_in, b_mag_in;
  logic [32:0] mul_sum;
  logic [32:0] div_sh, div_diff;
  logic        div_ge;
  logic [63:0] acc_nxt, prod;
  logic [31:0] quo, rem, hi_fin, lo_fin;

  assign issue_md  = bus.start && (state == IDLE) && !bus.op[2];
  assign last      = (state == RUN) && (cnt == 5'(ITERS - 1));
  assign signed_op = !bus.op[0];
  assign a_neg     = signed_op && bus.A[31];
  assign b_neg     = signed_op && bus.B[31];
  // 0x80000000 negates to itself, which read unsigned is exactly 2^31
  assign a_mag_in  = a_neg ? (32'd0 - bus.A) : bus.A;
  assign b_mag_in  = b_neg ? (32'd0 - bus.B) : bus.B;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_md) state_nxt = RUN;
      RUN:     if (last)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Multiply: acc = {partial product, multiplier shifting out LSB first}.
  // Divide:   acc = {partial remainder, dividend shifting into quotient bits}.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
  assign div_sh   = {acc[63:32], acc[31]};
  assign div_diff = div_sh - {1'b0, mag_b};
  assign div_ge   = (div_sh >= {1'b0, mag_b});
  assign acc_nxt  = is_div ? {(div_ge ? div_diff[31:0] : div_sh[31:0]), acc[30:0], div_ge}
                           : {mul_sum, acc[31:1]};

  assign prod   = neg_q ? (64'd0 - acc_nxt) : acc_nxt;
  assign quo    = neg_q ? (32'd0 - acc_nxt[31:0])  : acc_nxt[31:0];
  assign rem    = neg_r ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
  assign hi_fin = is_div ? rem : prod[63:32];
  assign lo_fin = is_div ? quo : prod[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && bus.op == OP_MTHI) hi_q <= bus.A;
        if (bus.start && bus.op == OP_MTLO) lo_q <= bus.A;
        if (issue_md) begin
          cnt    <= '0;
          mag_a  <= a_mag_in;
          mag_b  <= b_mag_in;
          is_div <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
          acc    <= {32'd0, bus.op[1] ? a_mag_in : b_mag_in};
          // Divide by zero leaves all-ones quotient unsigned; remainder still follows the dividend
          neg_q  <= (a_neg ^ b_neg) && !(bus.op[1] && bus.B == 32'd0);
          neg_r  <= a_neg;
        end
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 5'd1;
        if (last) begin
          hi_q   <= hi_fin;
          lo_q   <= lo_fin;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.HI_Q = hi_q;
  assign bus.LO_Q = lo_q;

endmodule
